reg_scoreboard: RTL
===================

// Module: reg_scoreboard
// PURPOSE
//   Parametrised register-file write-enable decoder with pending-write tracking for the pipelined core.
//   Decodes each issued destination register into a per-register in-flight counter.
//   Decodes each writeback address into a registered one-hot regfile write enable.
//   Flags RAW hazards on two source operands; sits between decode/issue and the register file.
// PARAMETERS
//   ADDR_W      5   register address width; NREG = 2**ADDR_W registers
//   CNT_W       2   per-register pending-write counter width; CNT_MAX = 2**CNT_W-1
//   ZERO_HW     1   1: register 0 hardwired; never tracked, never write-enabled
// PORTS
//   clk         in   1        clock, rising edge
//   rst_n       in   1        asynchronous reset, active-low
//   flush       in   1        synchronous clear of all pending counters
//   iss_valid   in   1        issue request this cycle
//   iss_wen     in   1        issued instruction writes iss_rd
//   iss_rd      in   ADDR_W   destination register of issued instruction
//   iss_ready   out  1        issue may proceed (combinational)
//   rs1, rs2    in   ADDR_W   source registers checked for hazards
//   rs1_hazard  out  1        rs1 has an unresolved pending write (combinational)
//   rs2_hazard  out  1        rs2 has an unresolved pending write (combinational)
//   wb_valid    in   1        writeback this cycle
//   wb_rd       in   ADDR_W   writeback destination register
//   wb_eni      out  NREG     registered one-hot regfile write enable
//   busy        out  NREG     busy[i] = (cnt[i] != 0)
//   wb_err      out  1        registered 1-cycle pulse: writeback to register with cnt==0
// BEHAVIOUR
//   Reset (rst_n=0, async): all cnt[i]=0, wb_eni=0, wb_err=0; busy=0; outputs hold until rst_n=1.
//   Reset mid-operation discards all pending state immediately; no writeback enable is generated.
//   zero(r) = ZERO_HW && r==0.
//   Issue fire: inc = iss_valid & iss_ready & iss_wen & !zero(iss_rd).
//   iss_ready = !(iss_wen & !zero(iss_rd) & cnt[iss_rd]==CNT_MAX).
//     - Depends only on the current cnt.
//     - Stays low at CNT_MAX even if a same-cycle wb to that register occurs (no wb lookahead).
//     - iss_valid with iss_wen=0: always ready; no counter change.
//   Writeback: dec = wb_valid & !zero(wb_rd) & cnt[wb_rd]!=0.
//   Underflow: wb_valid & !zero(wb_rd) & cnt[wb_rd]==0
//     - no decrement;
//     - wb_err=1 on next cycle;
//     - wb_eni still asserted.
//   Counter update, per register i, on next edge: cnt[i] <= cnt[i] + inc_i - dec_i (width CNT_W, never wraps).
//     - Same register issued and written back in one cycle: net unchanged.
//     - If cnt was 0 in that case: underflow rule applies, then +1 -> 1.
//   wb_eni (1-cycle latency): next cycle = one-hot(wb_rd) if wb_valid & !zero(wb_rd), else all-zero.
//     - At most one bit set.
//     - Independent of flush and counter state.
//   Hazard: rsN_hazard = !zero(rsN) & cnt[rsN]!=0 & !(wb_valid & wb_rd==rsN & cnt[rsN]==1).
//     - The last-outstanding write landing this cycle is bypassed (no hazard).
//     - An issue to rsN in the same cycle does not raise the hazard until the next cycle.
//   flush=1 (sync): all cnt <= 0 next edge, overriding same-cycle inc/dec; wb_eni/wb_err unaffected.
//   busy[0] always 0 when ZERO_HW=1; with ZERO_HW=0 register 0 is tracked like any other.
//   Implementation: no latches; all cnt/wb_eni/wb_err in one async-reset always block.
// TESTING
//   T1 reset: rst_n=0 then 1, no activity -> busy=0, wb_eni=0, iss_ready=1, no hazards.
//   T2 issue rd=5, next cycle wb rd=5 -> busy[5]=1 for 1 cycle; wb_eni=32'h0000_0020 one cycle after wb; busy[5]=0.
//   T3 issue rd=7 x3 (CNT_W=2) -> cnt=3.
//     - 4th issue rd=7: iss_ready=0, cnt stays 3.
//     - wb rd=7 same cycle -> cnt=2, ready=1 next cycle.
//   T4 issue rd=0 x5 (ZERO_HW=1) -> iss_ready=1 throughout, busy=0.
//     - Then wb rd=0 -> wb_eni=0, wb_err=0.
//   T5 hazard: cnt[3]=1, rs1=3 -> rs1_hazard=1; same cycle wb rd=3 -> rs1_hazard=0.
//     - With cnt[3]=2 plus wb rd=3 -> rs1_hazard=1.
//   T6 edge cases:
//     - wb rd=9 with cnt[9]=0 -> wb_err pulse, wb_eni[9]=1.
//     - flush with issue rd=4 -> cnt[4]=0.
//     - rst_n low mid-sequence -> all cleared asynchronously.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters, RAW hazard detection and registered one-hot regfile write enable
module reg_scoreboard #(
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 2,
    parameter int ZERO_HW = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 iss_valid,
    input  logic                 iss_wen,
    input  logic [ADDR_W-1:0]    iss_rd,
    output logic                 iss_ready,
    input  logic [ADDR_W-1:0]    rs1,
    input  logic [ADDR_W-1:0]    rs2,
    output logic                 rs1_hazard,
    output logic                 rs2_hazard,
    input  logic                 wb_valid,
    input  logic [ADDR_W-1:0]    wb_rd,
    output logic [2**ADDR_W-1:0] wb_eni,
    output logic [2**ADDR_W-1:0] busy,
    output logic                 wb_err
);
    localparam int NREG = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NREG-1:0] wb_eni_q, wb_eni_d;
    logic wb_err_q, wb_err_d;
    logic iss_zero, wb_zero, rs1_zero, rs2_zero, inc, dec, wb_act;
    always_comb begin
        iss_zero   = (ZERO_HW != 0) && (iss_rd == '0);
        wb_zero    = (ZERO_HW != 0) && (wb_rd == '0);
        rs1_zero   = (ZERO_HW != 0) && (rs1 == '0);
        rs2_zero   = (ZERO_HW != 0) && (rs2 == '0);
        iss_ready  = !(iss_wen && !iss_zero && cnt_q[iss_rd] == CNT_MAX);
        inc        = iss_valid && iss_ready && iss_wen && !iss_zero;
        wb_act     = wb_valid && !wb_zero;
        dec        = wb_act && cnt_q[wb_rd] != '0;
        wb_err_d   = wb_act && cnt_q[wb_rd] == '0;
        wb_eni_d   = wb_act ? {{(NREG-1){1'b0}}, 1'b1} << wb_rd : '0;
        // a write landing now that retires the last outstanding one is bypassed
        rs1_hazard = !rs1_zero && cnt_q[rs1] != '0 && !(wb_valid && wb_rd == rs1 && cnt_q[rs1] == CNT_ONE);
        rs2_hazard = !rs2_zero && cnt_q[rs2] != '0 && !(wb_valid && wb_rd == rs2 && cnt_q[rs2] == CNT_ONE);
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = flush ? '0 : cnt_q[i] + CNT_W'(inc && iss_rd == ADDR_W'(i))
                                             - CNT_W'(dec && wb_rd == ADDR_W'(i));
            busy[i]  = cnt_q[i] != '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            wb_eni_q <= '0;
            wb_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wb_eni_q <= wb_eni_d;
            wb_err_q <= wb_err_d;
        end
    end
    assign wb_eni = wb_eni_q;
    assign wb_err = wb_err_q;
endmodule
